fwd_clk_monitor: RTL and testbench



---
 rtl/fwd_clk_monitor.sv | 134 +++++++++++++
 tb/tb_fwd_clk_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_clk_monitor.sv
// Receive-side monitor for a forwarded clock: counts clk_in rising edges per
// gate window, tracks presence with a small FSM and flags loss stickily.
module fwd_clk_monitor #(
   parameter int GATE_CYCLES = 65536,
   parameter int CNT_W       = 17,
   parameter int MIN_EDGES   = 0,
   parameter int MAX_EDGES   = (1 << CNT_W) - 1,
   parameter int LOSS_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   input  logic             clear_sticky,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             cnt_valid,
   output logic             clk_present,
   output logic             clk_in_range,
   output logic             loss_sticky
);

   localparam int GATE_W = $clog2(GATE_CYCLES);
   localparam int IDLE_W = $clog2(LOSS_CYCLES + 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOSS_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {ABSENT, ACQUIRE, PRESENT} state_t;

   logic              s1, s2, s3;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_end;
   logic [CNT_W-1:0]  run_cnt;
   logic [CNT_W-1:0]  gate_total;
   logic              total_ok;
   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout;
   logic              loss_set;
   state_t            state, state_nxt;

   // s1 is the metastability stage; only s2/s3 feed logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise     = s2 & ~s3;
   assign gate_end = (gate_cnt == GATE_LAST);

   // An edge landing on the gate-end cycle belongs to the closing gate.
   assign gate_total = (rise && run_cnt != CNT_MAX) ? run_cnt + CNT_W'(1) : run_cnt;
   assign total_ok   = (int'(gate_total) >= MIN_EDGES) && (int'(gate_total) <= MAX_EDGES);
   assign timeout    = !rise && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
         run_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         gate_cnt <= gate_end ? '0 : gate_cnt + GATE_W'(1);
         if (gate_end)
            run_cnt <= '0;
         else
            run_cnt <= gate_total;
         if (rise)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_LAST)
            idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt     <= '0;
         cnt_valid    <= 1'b0;
         clk_in_range <= 1'b0;
      end else begin
         cnt_valid <= gate_end;
         if (gate_end) begin
            edge_cnt     <= gate_total;
            clk_in_range <= total_ok;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ABSENT;
      else
         state <= state_nxt;
   end

   // Timeout takes priority over a gate-end decision in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ABSENT:  if (rise) state_nxt = ACQUIRE;
         ACQUIRE: begin
            if (timeout)
               state_nxt = ABSENT;
            else if (gate_end && total_ok)
               state_nxt = PRESENT;
         end
         PRESENT: begin
            if (timeout)
               state_nxt = ABSENT;
            else if (gate_end && !total_ok)
               state_nxt = ACQUIRE;
         end
         default: state_nxt = ABSENT;
      endcase
   end

   assign clk_present = (state == PRESENT);
   assign loss_set    = (state == PRESENT) && (state_nxt != PRESENT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         loss_sticky <= 1'b0;
      else if (loss_set)
         loss_sticky <= 1'b1;
      else if (clear_sticky)
         loss_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_fwd_clk_monitor.sv
// Directed bench for fwd_clk_monitor: per-gate vector table plus hand
// sequences for loss, sticky precedence, saturation and mid-gate reset.
module tb_fwd_clk_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_in = 1'b0;
   logic        clear_sticky = 1'b0;
   logic [16:0] edge_cnt;
   logic        cnt_valid, clk_present, clk_in_range, loss_sticky;
   logic [3:0]  sat_cnt;
   logic        sat_valid, sat_present, sat_range, sat_sticky;

   fwd_clk_monitor #(.GATE_CYCLES(1000), .CNT_W(17), .MIN_EDGES(240),
                     .MAX_EDGES(260), .LOSS_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .clk_in(clk_in), .clear_sticky(clear_sticky),
      .edge_cnt(edge_cnt), .cnt_valid(cnt_valid), .clk_present(clk_present),
      .clk_in_range(clk_in_range), .loss_sticky(loss_sticky));

   fwd_clk_monitor #(.GATE_CYCLES(100), .CNT_W(4), .LOSS_CYCLES(16)) dut_sat (
      .clk(clk), .rst(rst), .clk_in(clk_in), .clear_sticky(clear_sticky),
      .edge_cnt(sat_cnt), .cnt_valid(sat_valid), .clk_present(sat_present),
      .clk_in_range(sat_range), .loss_sticky(sat_sticky));

   always #5 clk = ~clk;

   int half = 2;     // clk_in half period in clk cycles, 0 = held low
   int ph = 0;
   int cyc = 0;
   int last_hi = 0;
   int passed = 0;
   int total = 0;

   // clk_in generator, driven a little after each clk edge
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (half == 0) begin
            clk_in = 1'b0;
            ph = 0;
         end else begin
            ph++;
            if (ph >= half) begin
               ph = 0;
               clk_in = ~clk_in;
               if (clk_in) last_hi = cyc;
            end
         end
      end
   end

   task automatic chk_eq(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      total++;
      if (act >= lo && act <= hi) passed++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic wait_valid(input string name, input int bound);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cnt_valid && n < bound);
      if (!cnt_valid) begin
         total++;
         $display("FAIL %s: no cnt_valid within %0d cycles", name, bound);
      end
   endtask

   typedef struct {
      int half;
      int lo;
      int hi;
      bit present;
      bit in_range;
      bit sticky;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int k, n;
      bit found;
      tbl[0] = '{2, 247, 251, 1'b1, 1'b1, 1'b0};  // 25 MHz, first full gate locks
      tbl[1] = '{2, 247, 251, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{5,  97, 103, 1'b0, 1'b0, 1'b1};  // 10 MHz drops to ACQUIRE
      tbl[3] = '{2, 247, 251, 1'b1, 1'b1, 1'b1};  // back in range relocks

      #3;
      chk_eq("reset_edge_cnt", edge_cnt, 0);
      chk_eq("reset_cnt_valid", cnt_valid, 0);
      chk_eq("reset_present", clk_present, 0);
      chk_eq("reset_in_range", clk_in_range, 0);
      chk_eq("reset_sticky", loss_sticky, 0);
      repeat (4) @(negedge clk);
      rst = 1'b0;

      // CNT_W=4 instance: ~25 edges per gate must pin at 15
      for (int g = 0; g < 2; g++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!sat_valid && n < 150);
         chk_eq("sat_valid_seen", sat_valid, 1);
         chk_eq("sat_edge_cnt", sat_cnt, 15);
         chk_eq("sat_in_range", sat_range, 1);
      end

      for (int i = 0; i < 4; i++) begin
         half = tbl[i].half;
         wait_valid("gate_valid", 1100);
         chk_rng("gate_edge_cnt", edge_cnt, tbl[i].lo, tbl[i].hi);
         chk_eq("gate_present", clk_present, tbl[i].present);
         chk_eq("gate_in_range", clk_in_range, tbl[i].in_range);
         chk_eq("gate_sticky", loss_sticky, tbl[i].sticky);
         @(negedge clk);
         chk_eq("valid_one_cycle", cnt_valid, 0);
      end

      clear_sticky = 1'b1;
      @(negedge clk);
      clear_sticky = 1'b0;
      chk_eq("sticky_cleared", loss_sticky, 0);

      // Loss of clock: present drops 16 cycles after the last counted rise
      repeat (300) @(negedge clk);
      half = 0;
      repeat (2) @(negedge clk);
      k = last_hi;
      n = 0;
      while (cyc < k + 18 && n < 40) begin @(negedge clk); n++; end
      chk_eq("present_before_timeout", clk_present, 1);
      clear_sticky = 1'b1;  // same cycle as PRESENT -> ABSENT
      @(negedge clk);
      clear_sticky = 1'b0;
      chk_eq("present_after_timeout", clk_present, 0);
      chk_eq("sticky_set_wins", loss_sticky, 1);
      @(negedge clk);
      clear_sticky = 1'b1;
      @(negedge clk);
      clear_sticky = 1'b0;
      chk_eq("sticky_clear_alone", loss_sticky, 0);
      wait_valid("loss_gate_valid", 1100);
      chk_rng("loss_edge_cnt", edge_cnt, 0, 249);
      chk_eq("loss_in_range", clk_in_range, 0);
      chk_eq("loss_present", clk_present, 0);

      // Relock, then reset mid-gate
      half = 2;
      found = 1'b0;
      n = 0;
      while (!found && n < 4000) begin
         @(negedge clk);
         n++;
         if (cnt_valid && clk_present) found = 1'b1;
      end
      chk_eq("relock", found, 1);
      repeat (500) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_eq("rst_edge_cnt", edge_cnt, 0);
      chk_eq("rst_present", clk_present, 0);
      chk_eq("rst_in_range", clk_in_range, 0);
      chk_eq("rst_cnt_valid", cnt_valid, 0);
      chk_eq("rst_sticky", loss_sticky, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!cnt_valid && n < 1100);
      chk_eq("post_rst_gate_len", n, 1000);
      chk_rng("post_rst_edge_cnt", edge_cnt, 247, 251);
      chk_eq("post_rst_present", clk_present, 1);
      chk_eq("post_rst_in_range", clk_in_range, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
